pc_sequencer: RTL

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 112 +++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// Fetch-side program counter: sequential advance, stall hold and
// prioritised redirects (exception > jump > branch), with one deferred slot.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h00000000,
  parameter logic [31:0] EXC_VECTOR = 32'h80000180
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        exception,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        if_valid
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    STALL
  } state_t;

  state_t      state;
  logic        pend_valid;
  logic [31:0] pend_addr;
  logic [1:0]  pend_prio;
  logic        stall_redir;

  logic        redir;
  logic [1:0]  redir_prio;
  logic [31:0] redir_addr;

  assign redir = exception | jump | branch_taken;

  always_comb begin
    redir_prio = 2'd0;
    redir_addr = 32'h0;
    if (exception) begin
      redir_prio = 2'd3;
      redir_addr = EXC_VECTOR;
    end else if (jump) begin
      redir_prio = 2'd2;
      redir_addr = {jump_target[31:2], 2'b00};
    end else if (branch_taken) begin
      redir_prio = 2'd1;
      redir_addr = {branch_target[31:2], 2'b00};
    end
  end

  assign imem_req  = (state == FETCH);
  assign imem_addr = pc;
  assign pc_plus4  = pc + 32'd4;
  assign if_valid  = (state == FETCH) & imem_ready
                   & ~pend_valid & ~redir;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      pend_valid  <= 1'b0;
      pend_addr   <= 32'h0;
      pend_prio   <= 2'd0;
      stall_redir <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (redir) pc <= redir_addr;
          state <= FETCH;
        end
        FETCH: begin
          if (!imem_ready) begin
            // equal or higher priority replaces the deferred target
            if (redir && (!pend_valid || redir_prio >= pend_prio)) begin
              pend_valid <= 1'b1;
              pend_addr  <= redir_addr;
              pend_prio  <= redir_prio;
            end
          end else if (redir) begin
            pc         <= redir_addr;
            pend_valid <= 1'b0;
          end else if (pend_valid) begin
            pc         <= pend_addr;
            pend_valid <= 1'b0;
          end else if (stall) begin
            state       <= STALL;
            stall_redir <= 1'b0;
          end else begin
            pc <= pc_plus4;
          end
        end
        STALL: begin
          if (redir) begin
            pc          <= redir_addr;
            stall_redir <= 1'b1;
            if (!stall) state <= FETCH;
          end else if (!stall) begin
            if (!stall_redir) pc <= pc_plus4;
            state <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
